// File: rtl/dt_select_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : dt_select_sequencer_if
//  Brief    : Request/bus handshake bundle between the requester, the Dt-mux
//             select sequencer and the bus consumer.
//  Revision : 1.0
// ============================================================================
interface dt_select_sequencer_if;
    logic        req;
    logic [4:0]  src;
    logic        lowFirst;
    logic        single;
    logic        busReady;
    logic        abort;
    logic [18:0] notSel;
    logic        busy;
    logic        byteIdx;
    logic        done;
    logic        err;

    modport master (
        output req, src, lowFirst, single, busReady, abort,
        input  notSel, busy, byteIdx, done, err
    );

    modport slave (
        input  req, src, lowFirst, single, busReady, abort,
        output notSel, busy, byteIdx, done, err
    );
endinterface
`default_nettype wire

// File: rtl/dt_select_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : dt_select_sequencer
//  Brief    : Drives the active-low one-hot Dt-mux selects to move one byte or
//             a register pair onto the data bus, with back-pressure, abort and
//             a stall watchdog.
//  Revision : 1.0
// ============================================================================
module dt_select_sequencer #(
    parameter int TIMEOUT = 255
) (
    input  wire logic              clk,
    input  wire logic              notReset,
    dt_select_sequencer_if.slave   bus
);

    localparam logic [18:0] NSEL_IDLE = '1;
    localparam logic [7:0]  WD_LAST   = 8'(TIMEOUT - 1);
    localparam bit          WD_EN     = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BYTE0 = 2'd1,
        BYTE1 = 2'd2
    } state_t;

    state_t      state_q;
    logic [4:0]  src_q;
    logic        lowFirst_q;
    logic        twoByte_q;
    logic [18:0] notSel_q;
    logic        busy_q;
    logic        byteIdx_q;
    logic        done_q;
    logic        err_q;
    logic [7:0]  wdCnt_q;

    logic        w_srcValid;
    logic        w_srcPair;
    logic        w_wdExpire;

    // Select-bit index for a source code; 'high' picks the half of a pair.
    function automatic logic [4:0] sel_bit(input logic [4:0] code, input logic high);
        case (code)
            5'd0:    sel_bit = high ? 5'd0  : 5'd1;
            5'd1:    sel_bit = high ? 5'd2  : 5'd3;
            5'd2:    sel_bit = high ? 5'd4  : 5'd5;
            5'd3:    sel_bit = high ? 5'd18 : 5'd17;
            5'd4:    sel_bit = high ? 5'd6  : 5'd7;
            5'd5:    sel_bit = high ? 5'd8  : 5'd9;
            5'd6:    sel_bit = high ? 5'd10 : 5'd11;
            5'd7:    sel_bit = high ? 5'd12 : 5'd13;
            default: sel_bit = code - 5'd2;
        endcase
    endfunction

    function automatic logic [18:0] sel_vec(input logic [4:0] idx);
        sel_vec = ~(19'd1 << idx);
    endfunction

    assign w_srcValid = (bus.src <= 5'd18);
    assign w_srcPair  = (bus.src <= 5'd7);
    assign w_wdExpire = WD_EN && (wdCnt_q == WD_LAST);

    always_ff @(posedge clk or negedge notReset) begin
        if (!notReset) begin
            state_q    <= IDLE;
            src_q      <= 5'd0;
            lowFirst_q <= 1'b0;
            twoByte_q  <= 1'b0;
            notSel_q   <= NSEL_IDLE;
            busy_q     <= 1'b0;
            byteIdx_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wdCnt_q    <= 8'd0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req && !bus.abort) begin
                        if (w_srcValid) begin
                            state_q    <= BYTE0;
                            src_q      <= bus.src;
                            lowFirst_q <= bus.lowFirst;
                            twoByte_q  <= w_srcPair && !bus.single;
                            notSel_q   <= sel_vec(sel_bit(bus.src, !bus.lowFirst));
                            busy_q     <= 1'b1;
                            byteIdx_q  <= 1'b0;
                            wdCnt_q    <= 8'd0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                BYTE0, BYTE1: begin
                    if (bus.abort) begin
                        state_q   <= IDLE;
                        notSel_q  <= NSEL_IDLE;
                        busy_q    <= 1'b0;
                        byteIdx_q <= 1'b0;
                        wdCnt_q   <= 8'd0;
                    end else if (bus.busReady) begin
                        wdCnt_q <= 8'd0;
                        if (state_q == BYTE0 && twoByte_q) begin
                            // Second byte of a pair is the opposite half of the first.
                            state_q   <= BYTE1;
                            notSel_q  <= sel_vec(sel_bit(src_q, lowFirst_q));
                            byteIdx_q <= 1'b1;
                        end else begin
                            state_q   <= IDLE;
                            notSel_q  <= NSEL_IDLE;
                            busy_q    <= 1'b0;
                            byteIdx_q <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end else if (w_wdExpire) begin
                        state_q   <= IDLE;
                        notSel_q  <= NSEL_IDLE;
                        busy_q    <= 1'b0;
                        byteIdx_q <= 1'b0;
                        wdCnt_q   <= 8'd0;
                        err_q     <= 1'b1;
                    end else begin
                        wdCnt_q <= wdCnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    notSel_q  <= NSEL_IDLE;
                    busy_q    <= 1'b0;
                    byteIdx_q <= 1'b0;
                    wdCnt_q   <= 8'd0;
                end
            endcase
        end
    end

    assign bus.notSel  = notSel_q;
    assign bus.busy    = busy_q;
    assign bus.byteIdx = byteIdx_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;

endmodule
`default_nettype wire
